// File: rtl/result_store_seq.sv
// Sequences 16-bit result pairs into a byte-wide data memory: LSW at ptr, MSW at ptr+1.
// A run stores NUM_RESULTS pairs from base_addr, then holds done until the next start.
module result_store_seq #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_RESULTS = 15,
    localparam int unsigned CntW       = $clog2(NUM_RESULTS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_msw_i,
    input  logic [DATA_W-1:0] in_lsw_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CntW-1:0]   wr_count_o
);

    typedef enum logic [2:0] {StIdle, StArmed, StWrLo, StWrHi, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] msw_q, lsw_q;
    logic [CntW-1:0]   wr_count_q;
    logic              mem_we_q, busy_q, done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic last_pair;
    logic accept;

    // The pair being written in WR_HI is the last one of the run.
    assign last_pair  = (32'(wr_count_q) + 32'd1) == NUM_RESULTS;
    assign in_ready_o = (state_q == StArmed) || ((state_q == StWrHi) && !last_pair);
    // start wins over a coincident handshake.
    assign accept     = in_valid_i && in_ready_o && !start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            msw_q       <= '0;
            lsw_q       <= '0;
            wr_count_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (start_i) begin
            state_q    <= StArmed;
            ptr_q      <= base_addr_i;
            wr_count_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            mem_we_q   <= 1'b0;
        end else begin
            case (state_q)
                StArmed: begin
                    if (accept) begin
                        msw_q       <= in_msw_i;
                        lsw_q       <= in_lsw_i;
                        state_q     <= StWrLo;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= in_lsw_i;
                    end
                end
                StWrLo: begin
                    state_q     <= StWrHi;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q + ADDR_W'(1);
                    mem_wdata_q <= msw_q;
                end
                StWrHi: begin
                    ptr_q      <= ptr_q + ADDR_W'(2);
                    wr_count_q <= wr_count_q + CntW'(1);
                    if (last_pair) begin
                        state_q  <= StDone;
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (accept) begin
                        // Back-to-back pair: its LSW goes out next cycle at the advanced ptr.
                        msw_q       <= in_msw_i;
                        lsw_q       <= in_lsw_i;
                        state_q     <= StWrLo;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q + ADDR_W'(2);
                        mem_wdata_q <= in_lsw_i;
                    end else begin
                        state_q  <= StArmed;
                        mem_we_q <= 1'b0;
                    end
                end
                default: mem_we_q <= 1'b0;
            endcase
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_result_store_seq.sv
// Scoreboard bench for result_store_seq: expected memory writes are queued by the stimulus
// and popped by a monitor on every mem_we cycle; status outputs are checked directly.
module tb_result_store_seq;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 3;
    localparam int unsigned CW = $clog2(NR + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_msw, in_lsw;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy, done;
    logic [CW-1:0] wr_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    result_store_seq #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_RESULTS(NR)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .base_addr_i(base_addr),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_msw_i   (in_msw),
        .in_lsw_i   (in_lsw),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .busy_o     (busy),
        .done_o     (done),
        .wr_count_o (wr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    // Presents a pair and returns one cycle after the accepting edge, in_valid dropped.
    task automatic send_pair(input logic [DW-1:0] m, input logic [DW-1:0] l);
        int n = 0;
        in_valid = 1'b1;
        in_msw   = m;
        in_lsw   = l;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) begin
            checks++;
            failures++;
            $display("FAIL send_pair_timeout: got in_ready=0 expected 1 within 10 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every write cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL mem_write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_msw    = '0;
        in_lsw    = '0;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of an LSW write: everything clears before the next edge.
        do_start(8'h10);
        in_valid = 1'b1;
        in_msw   = 8'h55;
        in_lsw   = 8'h66;
        tick();
        in_valid = 1'b0;
        check("pre_reset_we", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_we", 32'(mem_we), 0);
        check("async_reset_addr", 32'(mem_addr), 0);
        check("async_reset_wdata", 32'(mem_wdata), 0);
        check("async_reset_busy", 32'(busy), 0);
        check("async_reset_ready", 32'(in_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(in_ready), 0);
        check("post_reset_done", 32'(done), 0);

        // in_valid while IDLE is ignored.
        in_valid = 1'b1;
        in_msw   = 8'hDE;
        in_lsw   = 8'hAD;
        repeat (3) tick();
        in_valid = 1'b0;
        check("idle_wr_count", 32'(wr_count), 0);
        check("idle_ready", 32'(in_ready), 0);

        // Single pair at 30/31.
        do_start(8'd30);
        check("armed_busy", 32'(busy), 1);
        expect_wr(8'd30, 8'h3C);
        expect_wr(8'd31, 8'hA5);
        send_pair(8'hA5, 8'h3C);
        tick();
        check("single_wrhi_ready", 32'(in_ready), 1);
        tick();
        check("single_wr_count", 32'(wr_count), 1);
        check("single_ready", 32'(in_ready), 1);

        // Full run with in_valid held: six back-to-back writes, then done.
        do_start(8'd30);
        expect_wr(8'd30, 8'hB1);
        expect_wr(8'd31, 8'hA1);
        expect_wr(8'd32, 8'hB2);
        expect_wr(8'd33, 8'hA2);
        expect_wr(8'd34, 8'hB3);
        expect_wr(8'd35, 8'hA3);
        in_valid = 1'b1;
        in_msw   = 8'hA1;
        in_lsw   = 8'hB1;
        tick();
        check("burst_we1", 32'(mem_we), 1);
        in_msw = 8'hA2;
        in_lsw = 8'hB2;
        tick();
        check("burst_we2", 32'(mem_we), 1);
        check("burst_ready_hi1", 32'(in_ready), 1);
        tick();
        check("burst_we3", 32'(mem_we), 1);
        in_msw = 8'hA3;
        in_lsw = 8'hB3;
        tick();
        check("burst_we4", 32'(mem_we), 1);
        tick();
        check("burst_we5", 32'(mem_we), 1);
        tick();
        check("burst_we6", 32'(mem_we), 1);
        check("burst_last_ready", 32'(in_ready), 0);
        tick();
        check("burst_done", 32'(done), 1);
        check("burst_busy", 32'(busy), 0);
        check("burst_wr_count", 32'(wr_count), 3);

        // in_valid still high in DONE: no writes, done holds.
        repeat (3) tick();
        in_valid = 1'b0;
        check("done_hold", 32'(done), 1);
        check("done_wr_count", 32'(wr_count), 3);
        check("done_ready", 32'(in_ready), 0);

        // Pointer wrap from 0xFF.
        do_start(8'hFF);
        check("restart_done_clr", 32'(done), 0);
        expect_wr(8'hFF, 8'h22);
        expect_wr(8'h00, 8'h11);
        expect_wr(8'h01, 8'h44);
        expect_wr(8'h02, 8'h33);
        send_pair(8'h11, 8'h22);
        send_pair(8'h33, 8'h44);
        tick();
        tick();
        check("wrap_wr_count", 32'(wr_count), 2);

        // start with coincident in_valid: pair dropped, count and pointer reset.
        start     = 1'b1;
        base_addr = 8'h50;
        in_valid  = 1'b1;
        in_msw    = 8'h77;
        in_lsw    = 8'h66;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_wins_count", 32'(wr_count), 0);
        check("start_wins_we", 32'(mem_we), 0);
        tick();
        check("start_wins_we2", 32'(mem_we), 0);
        expect_wr(8'h50, 8'h88);
        expect_wr(8'h51, 8'h99);
        send_pair(8'h99, 8'h88);
        tick();
        tick();
        check("new_base_count", 32'(wr_count), 1);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
